// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_pkg;

  localparam logic [31:0] FETCH_PC_STEP = 32'd4;

  typedef logic [31:0] pc_t;

  typedef struct packed {
    pc_t         pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic pc_t align_pc(input pc_t pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a registered head
// that keeps its last value while the FIFO is empty.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int FETCH_DEPTH = 2,
  localparam int CNT_W = $clog2(FETCH_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

  fetch_entry_t     mem [FETCH_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FETCH_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Head tracks the entry that will sit at rd_ptr after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
      if (push && ((count == '0) || (do_pop && (count == CNT_W'(1)))))
        head <= push_data;
      else if (do_pop && (count > CNT_W'(1)))
        head <= mem[next_ptr(rd_ptr)];
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, response FIFO, redirect flush.
// Optional IFETCH_STALL_CNT_EN adds a saturating decode-stall counter port.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FETCH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int CNT_W = $clog2(FETCH_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  pc_t              fetch_pc;
  pc_t              resp_pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] count;
  logic             credit_ok;
  logic             req_fire;
  logic             push;
  logic             pop;
  fetch_entry_t     push_data;
  fetch_entry_t     head;

  // Credits cover both outstanding requests and buffered words.
  assign credit_ok      = (SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(FETCH_DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push      = imem_resp_valid && !redirect_valid && (drop == '0);
  assign push_data = '{pc: resp_pc, instr: imem_resp_data};
  assign pop       = instr_valid && instr_ready;

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  fetch_fifo #(.FETCH_DEPTH(FETCH_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= align_pc(RESET_PC);
      resp_pc  <= align_pc(RESET_PC);
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        resp_pc  <= align_pc(redirect_pc);
        // Everything still outstanding after this cycle belongs to the old path.
        drop     <= inflight - CNT_W'(imem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + FETCH_PC_STEP;
        if (push)     resp_pc  <= resp_pc + FETCH_PC_STEP;
        if (imem_resp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (instr_valid && !instr_ready)
      stall_count <= sat_inc(stall_count);
  end
`endif

endmodule
